// File: rtl/logic_obs_shifter_pkg.sv
// Shared types and constants for the PP3 LOGIC-cell observation shifter.
package pp3_logic_obs_pkg;

    // Readback FSM states. All four 2-bit codes are used.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_FINISH  = 2'd3
    } obs_state_t;

    // Each LOGIC cell contributes one nibble to the frame.
    localparam int BITS_PER_CELL = 4;

    // Bit positions inside a cell nibble; TZ leaves the shifter first.
    localparam int TZ_POS = 0;
    localparam int CZ_POS = 1;
    localparam int QZ_POS = 2;
    localparam int FZ_POS = 3;

    // Assemble one cell's outputs into its frame nibble.
    function automatic logic [BITS_PER_CELL-1:0] pack_cell(
        input logic tz,
        input logic cz,
        input logic qz,
        input logic fz
    );
        logic [BITS_PER_CELL-1:0] nib;
        nib         = '0;
        nib[TZ_POS] = tz;
        nib[CZ_POS] = cz;
        nib[QZ_POS] = qz;
        nib[FZ_POS] = fz;
        return nib;
    endfunction

endpackage

// File: rtl/logic_obs_rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second rising clock edge after rst_n goes high.
module logic_obs_rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic meta;

    // Shift a constant 1 through two flops; any rst_n low clears both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= 1'b0;
            rst_n_sync <= 1'b0;
        end else begin
            meta       <= 1'b1;
            rst_n_sync <= meta;
        end
    end

endmodule

// File: rtl/logic_obs_shifter.sv
// Readback stage for a column of PP3 LOGIC cells: snapshots TZ/CZ/QZ/FZ of
// every cell into a shadow register and streams it out LSB first.
//
// Handshake: SO/SO_VALID/SO_LAST are driven from registered state only; a bit
// is transferred on a rising QCK edge where SO_VALID && SO_READY. While
// SO_VALID is high and SO_READY is low, SO and SO_LAST hold their value.
module logic_obs_shifter
    import pp3_logic_obs_pkg::*;
#(
    parameter int NUM_CELLS = 8
) (
    input  logic                 QCK,
    input  logic                 QRT_N,
    input  logic                 CAP_REQ,
    input  logic [NUM_CELLS-1:0] TZ,
    input  logic [NUM_CELLS-1:0] CZ,
    input  logic [NUM_CELLS-1:0] QZ,
    input  logic [NUM_CELLS-1:0] FZ,
    output logic                 SO,
    output logic                 SO_VALID,
    input  logic                 SO_READY,
    output logic                 SO_LAST,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [7:0]           FRAME_CNT,
    output logic [1:0]           dbg_state
);

    localparam int FRAME_W = BITS_PER_CELL * NUM_CELLS;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

    logic               rst_n_sync;
    obs_state_t         state;
    obs_state_t         state_nxt;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] capture_word;
    logic [CNT_W-1:0]   bit_cnt;
    logic [7:0]         frame_cnt;
    logic               in_shift;
    logic               at_last;
    logic               handshake;

    logic_obs_rst_sync u_rst_sync (
        .clk        (QCK),
        .rst_n      (QRT_N),
        .rst_n_sync (rst_n_sync)
    );

    assign in_shift  = (state == ST_SHIFT);
    assign at_last   = (bit_cnt == LAST_IDX);
    assign handshake = in_shift && SO_READY;

    // Gather the live cell outputs into frame order: cell 0 in the low nibble.
    always_comb begin
        capture_word = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            capture_word[i*BITS_PER_CELL +: BITS_PER_CELL] =
                pack_cell(TZ[i], CZ[i], QZ[i], FZ[i]);
        end
    end

    // State register; reset is released through the synchroniser.
    always_ff @(posedge QCK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. CAP_REQ is only looked at in IDLE, so requests
    // arriving mid-frame are dropped rather than queued.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (CAP_REQ) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (handshake && at_last) begin
                    state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shadow register and bit counter: load during CAPTURE, shift on handshake.
    // The counter wraps to 0 on the last bit so it never passes FRAME_W-1.
    always_ff @(posedge QCK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            shadow  <= '0;
            bit_cnt <= '0;
        end else if (state == ST_CAPTURE) begin
            shadow  <= capture_word;
            bit_cnt <= '0;
        end else if (handshake) begin
            shadow  <= {1'b0, shadow[FRAME_W-1:1]};
            bit_cnt <= at_last ? '0 : bit_cnt + 1'b1;
        end
    end

    // Completed-frame counter, bumped as FINISH is left; wraps naturally at 8 bits.
    always_ff @(posedge QCK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            frame_cnt <= '0;
        end else if (state == ST_FINISH) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end

    // Outputs decode directly from registered state, so they fall to zero the
    // moment reset is asserted.
    always_comb begin
        SO        = in_shift & shadow[0];
        SO_VALID  = in_shift;
        SO_LAST   = in_shift & at_last;
        BUSY      = (state != ST_IDLE);
        DONE      = (state == ST_FINISH);
        FRAME_CNT = frame_cnt;
        dbg_state = state;
    end

endmodule

// File: tb/tb_logic_obs_shifter.sv
// Self-checking bench for logic_obs_shifter with NUM_CELLS=2.
module tb_logic_obs_shifter;

  localparam int N  = 2;
  localparam int FW = 4 * N;

  logic         QCK = 1'b0;
  logic         QRT_N = 1'b0;
  logic         CAP_REQ = 1'b0;
  logic         SO_READY = 1'b0;
  logic [N-1:0] TZ = '0;
  logic [N-1:0] CZ = '0;
  logic [N-1:0] QZ = '0;
  logic [N-1:0] FZ = '0;
  logic         SO;
  logic         SO_VALID;
  logic         SO_LAST;
  logic         BUSY;
  logic         DONE;
  logic [7:0]   FRAME_CNT;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  logic [0:0] exp_q[$];

  logic_obs_shifter #(.NUM_CELLS(N)) dut (
    .QCK       (QCK),
    .QRT_N     (QRT_N),
    .CAP_REQ   (CAP_REQ),
    .TZ        (TZ),
    .CZ        (CZ),
    .QZ        (QZ),
    .FZ        (FZ),
    .SO        (SO),
    .SO_VALID  (SO_VALID),
    .SO_READY  (SO_READY),
    .SO_LAST   (SO_LAST),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .FRAME_CNT (FRAME_CNT),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 QCK = ~QCK;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: bit j of a frame is field (j%4) of cell (j/4); fields in order TZ,CZ,QZ,FZ
  function automatic logic frame_bit(input logic [N-1:0] tz, input logic [N-1:0] cz,
                                     input logic [N-1:0] qz, input logic [N-1:0] fz, input int j);
    int c;
    c = j / 4;
    case (j % 4)
      0: return tz[c];
      1: return cz[c];
      2: return qz[c];
      default: return fz[c];
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge QCK);
    QRT_N = 1'b0;
    repeat (2) @(negedge QCK);
    QRT_N = 1'b1;
    repeat (3) @(negedge QCK);
    exp_cnt = 0;
  endtask

  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready
  // abort_after > 0: assert reset right after that many bits are accepted
  task automatic run_frame(input logic [N-1:0] tz, input logic [N-1:0] cz,
                           input logic [N-1:0] qz, input logic [N-1:0] fz,
                           input int mode, input bit disturb, input int abort_after);
    int cyc;
    int got_bits;
    bit done_seen;
    bit aborted;
    bit prev_stall;
    logic prev_so;
    logic [0:0] e;
    cyc = 0; got_bits = 0; done_seen = 0; aborted = 0; prev_stall = 0; prev_so = 0;
    exp_q.delete();
    for (int j = 0; j < FW; j++) exp_q.push_back(frame_bit(tz, cz, qz, fz, j));
    @(negedge QCK);
    TZ = tz; CZ = cz; QZ = qz; FZ = fz;
    CAP_REQ = 1'b1;
    SO_READY = 1'b0;
    @(negedge QCK);
    CAP_REQ = 1'b0;
    check_val("busy_capture", BUSY, 1);
    check_val("valid_capture", SO_VALID, 0);
    while (!done_seen && !aborted && cyc < 400) begin
      @(negedge QCK);
      cyc++;
      if (prev_stall) begin
        check_val("stall_valid", SO_VALID, 1);
        check_val("stall_data", SO, prev_so);
      end
      if (cyc == 1) check_val("first_valid_latency", SO_VALID, 1);
      if (DONE) begin
        done_seen = 1;
        check_val("done_bits", got_bits, FW);
        check_val("done_valid", SO_VALID, 0);
        check_val("done_busy", BUSY, 1);
        if (mode == 0) check_val("done_latency", cyc, FW + 1);
        exp_cnt = (exp_cnt + 1) % 256;
      end else begin
        check_val("busy_shift", BUSY, 1);
        if (disturb && cyc == 1) begin
          TZ = ~tz; CZ = ~cz; QZ = ~qz; FZ = ~fz;
          CAP_REQ = 1'b1;
        end else begin
          CAP_REQ = 1'b0;
        end
        case (mode)
          0: SO_READY = 1'b1;
          1: SO_READY = (cyc % 3 == 1);
          default: SO_READY = 1'($urandom_range(0, 1));
        endcase
        if (SO_VALID && SO_READY) begin
          prev_stall = 0;
          if (exp_q.size() == 0) begin
            check_val("extra_bit", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_val("so_bit", SO, e);
            check_val("so_last", SO_LAST, (exp_q.size() == 0));
            got_bits++;
          end
          if (abort_after > 0 && got_bits == abort_after) begin
            @(posedge QCK);
            #2;
            QRT_N = 1'b0;
            #1;
            check_val("abort_valid", SO_VALID, 0);
            check_val("abort_busy", BUSY, 0);
            check_val("abort_done", DONE, 0);
            check_val("abort_cnt", FRAME_CNT, 0);
            exp_cnt = 0;
            aborted = 1;
          end
        end else begin
          prev_stall = SO_VALID;
          prev_so = SO;
        end
      end
    end
    CAP_REQ = 1'b0;
    if (aborted) begin
      repeat (3) begin
        @(negedge QCK);
        check_val("abort_no_done", DONE, 0);
      end
      QRT_N = 1'b1;
      repeat (3) @(negedge QCK);
      check_val("abort_cnt_after", FRAME_CNT, 0);
    end else if (!done_seen) begin
      check_val("frame_timeout", 0, 1);
    end else begin
      @(negedge QCK);
      check_val("busy_after", BUSY, 0);
      check_val("done_pulse", DONE, 0);
      check_val("frame_cnt", FRAME_CNT, exp_cnt);
      if (disturb) begin
        repeat (3) begin
          @(negedge QCK);
          check_val("no_second_frame", BUSY, 0);
        end
      end
    end
  endtask

  initial begin
    int waited;
    int dones;
    int bit_idx;
    int cyc;
    int done_age;
    logic [N-1:0] wt, wc, wq, wf;

    // reset / release with CAP_REQ already high
    QRT_N = 1'b0;
    CAP_REQ = 1'b1;
    SO_READY = 1'b1;
    repeat (3) @(negedge QCK);
    check_val("rst_so", SO, 0);
    check_val("rst_valid", SO_VALID, 0);
    check_val("rst_last", SO_LAST, 0);
    check_val("rst_busy", BUSY, 0);
    check_val("rst_done", DONE, 0);
    check_val("rst_cnt", FRAME_CNT, 0);
    QRT_N = 1'b1;
    @(negedge QCK);
    check_val("rel_edge1_busy", BUSY, 0);
    waited = 0;
    while (!BUSY && waited < 4) begin
      @(negedge QCK);
      waited++;
    end
    check_val("rel_busy_rise", BUSY, 1);
    CAP_REQ = 1'b0;
    waited = 0;
    while (!DONE && waited < 50) begin
      @(negedge QCK);
      waited++;
    end
    check_val("rel_frame_done", DONE, 1);
    @(negedge QCK);
    exp_cnt = 1;
    check_val("rel_frame_cnt", FRAME_CNT, exp_cnt);

    // directed frame, then same frame under backpressure
    run_frame(2'b01, 2'b10, 2'b11, 2'b00, 0, 0, 0);
    run_frame(2'b01, 2'b10, 2'b11, 2'b00, 1, 0, 0);

    // snapshot isolation with a request while busy
    run_frame(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 2, 1, 0);

    // mid-frame reset after the third accepted bit, then a clean frame
    run_frame(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 0, 0, 3);
    run_frame(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 0, 0, 0);

    // random frames
    for (int k = 0; k < 8; k++) begin
      run_frame(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end

    // counter wrap: 256 back-to-back frames from a fresh reset
    apply_reset();
    wt = 2'($urandom); wc = 2'($urandom); wq = 2'($urandom); wf = 2'($urandom);
    TZ = wt; CZ = wc; QZ = wq; FZ = wf;
    CAP_REQ = 1'b1;
    SO_READY = 1'b1;
    dones = 0; bit_idx = 0; cyc = 0; done_age = 0;
    while (dones < 256 && cyc < 256 * (FW + 4) + 20) begin
      @(negedge QCK);
      cyc++;
      if (done_age == 1) check_val("wrap_idle_gap", BUSY, 0);
      if (done_age == 2) check_val("wrap_restart", BUSY, 1);
      if (done_age > 0) done_age++;
      if (SO_VALID) begin
        check_val("wrap_bit", SO, frame_bit(wt, wc, wq, wf, bit_idx));
        bit_idx = (bit_idx + 1) % FW;
      end
      if (DONE) begin
        dones++;
        done_age = 1;
        if (dones == 256) CAP_REQ = 1'b0;
      end
    end
    check_val("wrap_dones", dones, 256);
    @(negedge QCK);
    check_val("wrap_cnt", FRAME_CNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
